// File: rtl/hps_reset_pulser_pkg.sv
// Shared types and helpers for the HPS reset-request pulser.
// The FSM state type, the edge-select encodings and two small helper
// functions live here: one finds the lowest requesting channel and one
// extracts a channel's pulse length with the zero-means-one clamp.
package hps_rst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    // Upper bounds that the helper functions are written against.
    localparam int MAX_CH      = 32;
    localparam int MAX_FIELD_W = 1024;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic int unsigned lowest_set(input logic [MAX_CH-1:0] v);
        int unsigned        idx;
        logic [MAX_CH-1:0]  t;
        idx = 0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            t = v >> i;
            if (t[0]) idx = i;
        end
        return idx;
    endfunction

    // Pulse length of channel ch from a packed field vector; 0 reads as 1.
    function automatic int unsigned pulse_len(input logic [MAX_FIELD_W-1:0] fields,
                                              input int unsigned ch,
                                              input int unsigned cnt_w);
        logic [MAX_FIELD_W-1:0] sh;
        logic [31:0]            len;
        sh  = fields >> (ch * cnt_w);
        len = sh[31:0];
        if (cnt_w < 32) len = len & ((32'd1 << cnt_w) - 32'd1);
        if (len == 32'd0) len = 32'd1;
        return len;
    endfunction

endpackage

// File: rtl/hps_reset_pulser_edge_sync.sv
// One request channel front end: two-flop synchroniser, previous-value
// register and a registered edge flag filtered by the channel's edge select.
// en holds the edge flag low until the parent has finished priming.
module hps_rst_edge_sync #(
    parameter logic [1:0] EDGE_SEL = 2'b01
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic en,
    output logic edge_q
);

    logic sync1;
    logic sync2;
    logic prev;
    logic rise;
    logic fall;
    logic det;

    assign rise = sync2 & ~prev;
    assign fall = ~sync2 & prev;
    assign det  = (EDGE_SEL[0] & rise) | (EDGE_SEL[1] & fall);

    // Synchronise the raw level, remember it, and register the qualified edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            prev   <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync1  <= din;
            sync2  <= sync1;
            prev   <= sync2;
            edge_q <= en & det;
        end
    end

endmodule

// File: rtl/hps_reset_pulser.sv
// Multi-channel reset-request pulse generator feeding the HPS f2h
// cold/warm/debug reset request inputs. Fixed priority (channel 0 highest),
// one pulse at a time followed by a global holdoff window. Busy-time edges
// are dropped or queued in a 1-deep per-channel pending flag.
// Optional build macro HPS_RST_PULSE_STATS_EN adds ev_cnt/drop_cnt counters.
module hps_reset_pulser
    import hps_rst_pkg::*;
#(
    parameter int                       NUM_CH            = 3,
    parameter int                       CNT_W             = 8,
    parameter logic [NUM_CH*CNT_W-1:0]  PULSE_EXT         = {8'd32, 8'd2, 8'd6},
    parameter logic [NUM_CH*2-1:0]      EDGE_TYPE         = {2'b01, 2'b01, 2'b01},
    parameter int                       HOLDOFF           = 16,
    parameter int                       IGNORE_WHILE_BUSY = 1,
    localparam int                      CH_W              = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   signal_in,
    output logic [NUM_CH-1:0]   pulse_out,
    output logic                busy,
    output logic [CH_W-1:0]     active_ch,
    output logic [NUM_CH-1:0]   pending,
    output logic                drop_stb
`ifdef HPS_RST_PULSE_STATS_EN
    ,
    output logic [NUM_CH*16-1:0] ev_cnt,
    output logic [15:0]          drop_cnt
`endif
);

    logic [1:0]         prime_cnt;
    logic               primed;
    logic [NUM_CH-1:0]  edges;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CH_W-1:0]    act;

    logic [NUM_CH-1:0]  cand;
    logic               start;
    logic [CH_W-1:0]    win;
    logic [NUM_CH-1:0]  win_oh;
    logic [CNT_W-1:0]   ext;
    logic [NUM_CH-1:0]  rest;
    logic [NUM_CH-1:0]  self_hit;
    logic [NUM_CH-1:0]  drops;
    logic [NUM_CH-1:0]  queue;
    logic [NUM_CH-1:0]  pend_nxt;

    assign primed    = (prime_cnt == 2'd3);
    assign busy      = (state != ST_IDLE);
    assign active_ch = act;

    // Count three cycles after reset release before letting edges through.
    always_ff @(posedge clk) begin
        if (rst) begin
            prime_cnt <= 2'd0;
        end else if (!primed) begin
            prime_cnt <= prime_cnt + 2'd1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        hps_rst_edge_sync #(
            .EDGE_SEL (EDGE_TYPE[2*i +: 2])
        ) u_sync (
            .clk    (clk),
            .rst    (rst),
            .din    (signal_in[i]),
            .en     (primed),
            .edge_q (edges[i])
        );
    end

    // Arbitration: pick the winner and sort every other edge into queue or drop.
    always_comb begin
        cand     = edges | pending;
        start    = (state == ST_IDLE) && (cand != '0);
        win      = CH_W'(lowest_set(MAX_CH'(cand)));
        win_oh   = NUM_CH'(1) << win;
        ext      = CNT_W'(pulse_len(MAX_FIELD_W'(PULSE_EXT), 32'(win), CNT_W));
        rest     = start ? (edges & ~win_oh) : edges;
        self_hit = (state == ST_PULSE) ? (edges & (NUM_CH'(1) << act)) : '0;
        if (IGNORE_WHILE_BUSY != 0) begin
            drops = rest;
            queue = '0;
        end else begin
            drops = self_hit | (rest & pending);
            queue = rest & ~self_hit & ~pending;
        end
        pend_nxt = (start ? (pending & ~win_oh) : pending) | queue;
    end

    // Pulse FSM with registered pulse, pending and drop outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            act       <= '0;
            pulse_out <= '0;
            pending   <= '0;
            drop_stb  <= 1'b0;
        end else begin
            pending  <= pend_nxt;
            drop_stb <= (drops != '0);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_PULSE;
                        cnt       <= ext;
                        act       <= win;
                        pulse_out <= win_oh;
                    end
                end
                ST_PULSE: begin
                    if (cnt <= CNT_W'(1)) begin
                        pulse_out <= '0;
                        if (HOLDOFF > 0) begin
                            state <= ST_HOLDOFF;
                            cnt   <= CNT_W'(HOLDOFF);
                        end else begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                            act   <= '0;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt <= CNT_W'(1)) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        act   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cnt       <= '0;
                    act       <= '0;
                    pulse_out <= '0;
                end
            endcase
        end
    end

`ifdef HPS_RST_PULSE_STATS_EN
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ev
        // Saturating count of pulses started on this channel.
        always_ff @(posedge clk) begin
            if (rst) begin
                ev_cnt[i*16 +: 16] <= 16'd0;
            end else if (start && (win == CH_W'(i)) && (ev_cnt[i*16 +: 16] != 16'hFFFF)) begin
                ev_cnt[i*16 +: 16] <= ev_cnt[i*16 +: 16] + 16'd1;
            end
        end
    end

    // Saturating count of drop strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= 16'd0;
        end else if (drop_stb && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule
